buzzer_event_decoder: RTL
=========================

# buzzer_event_decoder

Monitor-side decoder for the three one-hot buzzer lines produced by the sensor/buzzer alarm controller. It tracks each buzzer pulse, measures its length in clock cycles and checks that exactly one line is active. It then emits one event word per pulse through a 4-deep valid/ready queue. It sits between the alarm controller outputs and the logging/host-readout logic.

## Interface
- `PULSE_LEN`, default 31: nominal buzzer pulse length in cycles. Sets the match flag.
- `FIFO_DEPTH`, default 4: event queue depth. Must be a power of two.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `ena`  in  1: decoder enable. Low freezes the FSM and length counter. Queue pops still work.
- `buzz`  in  3: buzzer lines. Bit 0 is channel 1, bit 2 is channel 3. Sampled every edge.
- `evt_valid`  out  1: queue non-empty.
- `evt_ready`  in  1: consumer accepts the head word.
- `evt_data`  out  9: head event word. Bit 8 is match, bits 7:6 are the channel (0 = error), bits 5:0 are the length.
- `ovf`  out  1: sticky flag. Set when an event is dropped because the queue was full.
- `busy`  out  1: high while the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ACTIVE and ERROR. Registers: `ch` (2 bits) and `len` (6 bits).
- **IDLE**
  - `buzz==000`: stay in IDLE.
  - `buzz` one-hot: go to ACTIVE, `ch` = index+1, `len` = 1.
  - `buzz` multi-hot: push error word {0, 00, 000000}, go to ERROR.
- **ACTIVE**
  - `buzz` equals the latched one-hot: `len` increments, saturating at 63.
  - `buzz==000`: push {`len==PULSE_LEN`, `ch`, `len`}, go to IDLE.
  - Any other nonzero `buzz`: push error word {0, 00, `len`}, go to ERROR.
- **ERROR**
  - Stay until `buzz==000` is sampled, then go to IDLE.
  - No further events are generated in this state.
- Match flag is computed on the saturated 6-bit length. `PULSE_LEN` ≥ 63 matches only saturated pulses.
- `ena` low: state, `ch` and `len` hold, `buzz` is ignored and no pushes occur. A pulse that ends while `ena` is low is measured as if it were still held.
- **Queue**
  - Push and pop happen on the same edge.
  - Full with push and no pop: the word is dropped and `ovf` is set.
  - Full with push and pop: both are accepted and no drop occurs.
  - Empty with push: `evt_valid` rises the next cycle. There is no bypass.
  - `ovf` is cleared only by `rst`.
- **Reset values**
  - FSM goes to IDLE. `ch`, `len` and queue pointers/count are 0.
  - Outputs: `evt_valid`=0, `evt_data`=0, `ovf`=0, `busy`=0.
  - Reset mid-pulse discards the pulse with no event. Reset also discards queued words.

## Timing
- A pulse asserted for N sampled edges reports `len`=N, saturated at 63.
- Terminating edge E samples `buzz==000`. The word is written at E and `evt_valid`=1 in the cycle after E. Latency is 1 cycle.
- Multi-hot in IDLE sampled at edge E: the error word is written at E and `busy`=1 after E.
- `evt_data` is registered storage at the read pointer. It is stable while `evt_valid` is high and `evt_ready` is low.
- Handshake: a transfer occurs on an edge where `evt_valid && evt_ready`. `evt_data` advances the following cycle.
- After a pulse ends, a new pulse may start on the very next edge.

## Structure
- Package `buzzer_pkg`:
  - FSM state enum (IDLE/ACTIVE/ERROR).
  - Event field positions: MATCH_BIT=8, CH_MSB=7, CH_LSB=6, LEN_W=6.
  - Channel codes CH_ERR=0, CH1..CH3.
  - Default PULSE_LEN=31.
- Sub-module `evt_fifo`: synchronous FIFO, width 9, depth `FIFO_DEPTH`. Provides push, pop, full, empty and the overflow pulse. Top level holds the FSM, length counter and sticky `ovf`.

## Test plan
- Reset: assert `rst` for 2 cycles with `buzz=111` → `evt_valid`=0, `evt_data`=0, `ovf`=0, `busy`=0 on release.
- `buzz=001` for 31 edges then 000, `evt_ready`=1 → exactly one word `9'h15F`, with `evt_valid` for 1 cycle.
- `buzz=010` for 5 edges then 000 → `9'h085`. `buzz=100` for 80 edges → `9'h0FF` (saturated, no match).
- `buzz=011` from IDLE → `9'h000`, `busy`=1 until `000` is sampled. Separately, `001`×3 then `101` → `9'h003`, then ERROR.
- `evt_ready`=0 with five 2-cycle pulses on channel 1 → four words `9'h042` held in order, fifth dropped, `ovf`=1. Drain with `evt_ready`=1 → four transfers, `ovf` stays 1.
- `buzz=001` for 10 edges, `ena`=0 for 5 edges, then `ena`=1 for 4 more edges of `001` then 000 → `9'h04E`. `rst` mid-pulse → no event.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer event decoder.
//  - FSM state encoding
//  - Event word field positions and channel codes
//  - Default nominal pulse length and small helper functions
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    // Event word layout: {match, channel[1:0], length[5:0]}
    localparam int MATCH_BIT = 8;
    localparam int CH_MSB    = 7;
    localparam int CH_LSB    = 6;
    localparam int LEN_W     = 6;
    localparam int EVT_W     = 9;

    localparam logic [1:0] CH_ERR = 2'd0;
    localparam logic [1:0] CH1    = 2'd1;
    localparam logic [1:0] CH2    = 2'd2;
    localparam logic [1:0] CH3    = 2'd3;

    localparam int PULSE_LEN_DEF = 31;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    // Length value that raises the match flag. Nominal lengths beyond the
    // counter range can only ever be seen as a saturated count.
    function automatic logic [LEN_W-1:0] match_target(input int pulse_len);
        if (pulse_len >= 63) begin
            return LEN_MAX;
        end else if (pulse_len < 0) begin
            return '0;
        end else begin
            return LEN_W'(pulse_len);
        end
    endfunction

    // Buzzer pattern that corresponds to a latched channel code.
    function automatic logic [2:0] ch_to_buzz(input logic [1:0] ch);
        case (ch)
            CH1:     return 3'b001;
            CH2:     return 3'b010;
            CH3:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/buzzer_event_decoder_if.sv
// Event stream interface between the decoder and its consumer.
//  evt_valid : head word present (producer -> consumer)
//  evt_data  : head event word   (producer -> consumer)
//  evt_ready : consumer accepts  (consumer -> producer)
interface buzzer_event_decoder_if;
    import buzzer_pkg::*;

    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/buzzer_event_decoder_evt_fifo.sv
// Synchronous event FIFO with a registered head word.
//  clk, rst     : clock, synchronous active-high reset
//  push/push_data : write request and word
//  pop          : read request (ignored when empty)
//  empty        : no words stored
//  head_data    : registered word at the read pointer
//  ovf_pulse    : one-cycle flag when a push is dropped (full, no pop)
// DEPTH must be a power of two and at least 2.
module evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic             ovf_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] head_q,   head_d;

    logic full;
    logic pop_ok;
    logic push_ok;
    logic [AW-1:0] rd_ptr_inc;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign pop_ok     = pop && !empty;
    // A full queue still takes a word if the head leaves on the same edge.
    assign push_ok    = push && (!full || pop_ok);
    assign ovf_pulse  = push && full && !pop_ok;
    assign rd_ptr_inc = rd_ptr_q + 1'b1;
    assign head_data  = head_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_inc;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head register tracks the word at the next read pointer. When the
        // word being written lands exactly there it is forwarded, since the
        // array write is not yet visible.
        if (pop_ok) begin
            if (push_ok && (wr_ptr_q == rd_ptr_inc)) begin
                head_d = push_data;
            end else begin
                head_d = mem[rd_ptr_inc];
            end
        end else if (empty && push_ok) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/buzzer_event_decoder.sv
// Monitor-side decoder for the three one-hot buzzer lines.
// Measures each pulse, flags multi-hot errors and queues one event per pulse.
//  clk, rst : clock, synchronous active-high reset
//  ena      : decoder enable (low freezes FSM/counter; queue still drains)
//  buzz[2:0]: buzzer lines, bit 0 = channel 1
//  evt      : event stream (evt_valid / evt_ready / evt_data)
//  ovf      : sticky, an event was dropped on a full queue
//  busy     : FSM is not idle
module buzzer_event_decoder
    import buzzer_pkg::*;
#(
    parameter int PULSE_LEN  = PULSE_LEN_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [2:0]                  buzz,
    buzzer_event_decoder_if.master      evt,
    output logic                        ovf,
    output logic                        busy
);
    localparam logic [LEN_W-1:0] MATCH_LEN = match_target(PULSE_LEN);

    state_e           state_q, state_d;
    logic [1:0]       ch_q,    ch_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             ovf_q,   ovf_d;

    logic             push;
    logic [EVT_W-1:0] push_data;
    logic             fifo_empty;
    logic             fifo_ovf;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        len_d     = len_q;
        push      = 1'b0;
        push_data = '0;

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    case (buzz)
                        3'b000: state_d = ST_IDLE;
                        3'b001: begin state_d = ST_ACTIVE; ch_d = CH1; len_d = 6'd1; end
                        3'b010: begin state_d = ST_ACTIVE; ch_d = CH2; len_d = 6'd1; end
                        3'b100: begin state_d = ST_ACTIVE; ch_d = CH3; len_d = 6'd1; end
                        default: begin
                            push    = 1'b1;
                            state_d = ST_ERROR;
                        end
                    endcase
                end
                ST_ACTIVE: begin
                    if (buzz == ch_to_buzz(ch_q)) begin
                        len_d = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
                    end else if (buzz == 3'b000) begin
                        push                           = 1'b1;
                        push_data[MATCH_BIT]           = (len_q == MATCH_LEN);
                        push_data[CH_MSB:CH_LSB]       = ch_q;
                        push_data[LEN_W-1:0]           = len_q;
                        state_d                        = ST_IDLE;
                    end else begin
                        // Channel changed or a second line joined: error
                        // word keeps the length seen so far.
                        push                     = 1'b1;
                        push_data[CH_MSB:CH_LSB] = CH_ERR;
                        push_data[LEN_W-1:0]     = len_q;
                        state_d                  = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (buzz == 3'b000) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ovf_d = ovf_q | fifo_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (evt.evt_ready),
        .empty     (fifo_empty),
        .head_data (evt.evt_data),
        .ovf_pulse (fifo_ovf)
    );

    assign evt.evt_valid = !fifo_empty;
    assign ovf           = ovf_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
